apb_multi_sampler: RTL and testbench

//  Multi-channel periodic sampler acting as APB3 write master. A free-running tick snapshots NUM_CH input words.

---
 rtl/apb_multi_sampler_pkg.sv | 16 +
 rtl/apb_multi_sampler_tick_gen.sv | 19 +
 rtl/apb_multi_sampler.sv | 92 +++++++++
 tb/tb_apb_multi_sampler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_multi_sampler_pkg.sv
// apb_sampler_pkg: FSM state codes and helpers shared by the sampler files
package apb_sampler_pkg;
  localparam logic [1:0] IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [3:0] lowest_set(input logic [15:0] mask);
    logic [3:0] r;
    r = '0;
    for (int i = 15; i >= 0; i--) if (mask[i]) r = 4'(i);
    return r;
  endfunction
endpackage

// File: rtl/apb_multi_sampler_tick_gen.sv
// sample_tick_gen: one-cycle tick every PERIOD clocks, first one PERIOD cycles after reset
module sample_tick_gen import apb_sampler_pkg::*; #(
  parameter int PERIOD = 17
) (
  input  logic pclk_i,
  input  logic presetn_i,
  output logic tick_o
);
  localparam int CW = clog2(PERIOD);
  localparam logic [CW-1:0] RELOAD = CW'(PERIOD - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick_o = cnt_q == '0;
    cnt_d = tick_o ? RELOAD : cnt_q - 1'b1;
  end
  always_ff @(posedge pclk_i or negedge presetn_i)
    if (!presetn_i) cnt_q <= RELOAD;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/apb_multi_sampler.sv
// apb_multi_sampler: periodic multi-channel snapshot written out over APB3, lowest channel first
module apb_multi_sampler import apb_sampler_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int PERIOD = 17,
  parameter int ADDR_BASE = 0,
  parameter int ADDR_LAST = 255,
  parameter int ADDR_STEP = 1
) (
  input  logic                     pclk_i,
  input  logic                     presetn_i,
  input  logic [NUM_CH*DATA_W-1:0] data_i,
  input  logic [NUM_CH-1:0]        ch_en_i,
  input  logic                     pready_i,
  input  logic                     pslverr_i,
  input  logic [DATA_W-1:0]        prdata_i,
  output logic                     psel_o,
  output logic                     penable_o,
  output logic                     pwrite_o,
  output logic [ADDR_W-1:0]        paddr_o,
  output logic [DATA_W-1:0]        pwdata_o,
  output logic                     busy_o,
  output logic                     overrun_o,
  output logic [7:0]               err_cnt_o
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(ADDR_BASE);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ADDR_LAST);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);
  logic [1:0] state_q, state_d;
  logic [NUM_CH-1:0] pending_q, pending_d, clr, left;
  logic [NUM_CH*DATA_W-1:0] frame_q, frame_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d, word;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic [3:0] sel, nsel;
  logic tick, done, capture, unused_ok;
  sample_tick_gen #(.PERIOD(PERIOD)) u_tick (
    .pclk_i   (pclk_i),
    .presetn_i(presetn_i),
    .tick_o   (tick)
  );
  // the channel in flight is always the lowest pending bit, so no select register is kept
  always_comb begin
    sel = lowest_set(16'(pending_q));
    done = state_q == ACCESS && pready_i;
    clr = done ? NUM_CH'(1) << sel : '0;
    left = pending_q & ~clr;
    capture = tick && left == '0;
    pending_d = capture ? ch_en_i : left;
    frame_d = capture ? data_i : frame_q;
    nsel = lowest_set(16'(pending_d));
    word = '0;
    for (int k = 0; k < NUM_CH; k++) if (4'(k) == nsel) word = frame_d[k*DATA_W +: DATA_W];
    paddr_d = !done ? paddr_q : paddr_q == LAST ? BASE : paddr_q + STEP;
    err_cnt_d = done && pslverr_i && err_cnt_q != 8'hff ? err_cnt_q + 8'd1 : err_cnt_q;
  end
  always_comb begin
    state_d = state_q == ACCESS && !pready_i ? ACCESS :
              state_q == SETUP ? ACCESS :
              pending_d != '0 ? SETUP : IDLE;
    pwdata_d = state_d == SETUP ? word : state_d == IDLE ? '0 : pwdata_q;
  end
  always_comb begin
    psel_o = state_q == SETUP || state_q == ACCESS;
    penable_o = state_q == ACCESS;
    pwrite_o = psel_o;
    busy_o = pending_q != '0 || state_q != IDLE;
    overrun_o = tick && !capture;
    paddr_o = paddr_q;
    pwdata_o = pwdata_q;
    err_cnt_o = err_cnt_q;
    unused_ok = ^prdata_i;
  end
  always_ff @(posedge pclk_i or negedge presetn_i)
    if (!presetn_i) state_q <= IDLE;
    else state_q <= state_d;
  always_ff @(posedge pclk_i or negedge presetn_i)
    if (!presetn_i) begin
      pending_q <= '0;
      frame_q <= '0;
      paddr_q <= BASE;
      pwdata_q <= '0;
      err_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      frame_q <= frame_d;
      paddr_q <= paddr_d;
      pwdata_q <= pwdata_d;
      err_cnt_q <= err_cnt_d;
    end
endmodule

// File: tb/tb_apb_multi_sampler.sv
// tb_apb_multi_sampler: directed frames, scoreboard of expected APB writes checked by a monitor
module tb_apb_multi_sampler;
  localparam int P = 12;
  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    int          w;
    logic        err;
  } txn_t;
  logic pclk_i = 0, presetn_i = 0;
  logic [127:0] data_i;
  logic [3:0] ch_en_i;
  logic pready_i, pslverr_i;
  logic [31:0] prdata_i;
  logic psel_o, penable_o, pwrite_o, busy_o, overrun_o;
  logic [7:0] paddr_o, err_cnt_o;
  logic [31:0] pwdata_o;
  txn_t sb[$], rsp_q[$];
  int checks = 0, errors = 0, cyc = 0, ovr_n = 0;
  logic [7:0] exp_addr = 8'd8;
  apb_multi_sampler #(.NUM_CH(4), .DATA_W(32), .ADDR_W(8), .PERIOD(P),
                      .ADDR_BASE(8), .ADDR_LAST(10), .ADDR_STEP(1)) dut (
    .pclk_i(pclk_i), .presetn_i(presetn_i), .data_i(data_i), .ch_en_i(ch_en_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .paddr_o(paddr_o),
    .pwdata_o(pwdata_o), .busy_o(busy_o), .overrun_o(overrun_o), .err_cnt_o(err_cnt_o)
  );
  initial forever #5 pclk_i = ~pclk_i;
  always @(posedge pclk_i or negedge presetn_i)
    if (!presetn_i) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // drive one frame's inputs and queue the writes it should produce (waits: 8 bits per channel)
  task automatic frame(input logic [3:0] en, input logic [127:0] d, input logic [31:0] waits,
                       input logic [3:0] errs);
    txn_t e;
    ch_en_i = en;
    data_i = d;
    for (int k = 0; k < 4; k++) if (en[k]) begin
      e.addr = exp_addr;
      e.data = d[k*32 +: 32];
      e.w = int'(waits[k*8 +: 8]);
      e.err = errs[k];
      sb.push_back(e);
      rsp_q.push_back(e);
      exp_addr = exp_addr == 8'd10 ? 8'd8 : exp_addr + 8'd1;
    end
  endtask
  task automatic tick_wait();
    do begin @(posedge pclk_i); #1; end while (cyc % P != 0);
  endtask
  task automatic wait_cyc(input int n);
    for (int i = 0; i < 200 && cyc != n; i++) begin @(posedge pclk_i); #1; end
  endtask
  initial begin
    txn_t r;
    int cnt;
    pready_i = 0;
    pslverr_i = 0;
    cnt = 0;
    r.err = 0;
    forever begin
      @(posedge pclk_i); #1;
      if (psel_o && !penable_o && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        cnt = r.w;
        pready_i = cnt == 0;
        pslverr_i = cnt == 0 && r.err;
      end else if (psel_o && penable_o && !pready_i) begin
        if (cnt == 0) begin
          pready_i = 1;
          pslverr_i = r.err;
        end else cnt--;
      end else if (!psel_o) begin
        pready_i = 0;
        pslverr_i = 0;
      end
    end
  end
  initial begin
    int ts;
    logic [7:0] sa;
    logic [31:0] sd;
    txn_t e;
    ts = 0;
    sa = '0;
    sd = '0;
    forever begin
      @(negedge pclk_i);
      if (overrun_o) ovr_n++;
      if (psel_o && !penable_o) begin
        ts = cyc;
        sa = paddr_o;
        sd = pwdata_o;
      end
      if (psel_o && penable_o) begin
        chk("hold_paddr", paddr_o, sa);
        chk("hold_pwdata", pwdata_o, sd);
        chk("pwrite", pwrite_o, 1);
        if (pready_i) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: got paddr %0h pwdata %0h, want no transfer", paddr_o, pwdata_o);
          end else begin
            e = sb.pop_front();
            chk("paddr", paddr_o, e.addr);
            chk("pwdata", pwdata_o, e.data);
            chk("txn_cycles", cyc - ts, e.w + 1);
          end
        end
      end
    end
  end
  initial begin
    data_i = '0;
    ch_en_i = '0;
    prdata_i = '0;
    repeat (3) @(negedge pclk_i);
    chk("rst_psel", psel_o, 0);
    chk("rst_penable", penable_o, 0);
    chk("rst_pwrite", pwrite_o, 0);
    chk("rst_pwdata", pwdata_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_overrun", overrun_o, 0);
    chk("rst_err", err_cnt_o, 0);
    chk("rst_paddr", paddr_o, 8);
    presetn_i = 1;
    frame(4'b1111, {32'h44440003, 32'h33330002, 32'h22220001, 32'h11110000}, 0, 4'b0000);
    wait_cyc(P - 1);
    chk("pre_tick_psel", psel_o, 0);
    chk("pre_tick_busy", busy_o, 0);
    tick_wait();
    chk("latency_psel", psel_o, 1);
    chk("setup_penable", penable_o, 0);
    frame(4'b1111, {32'hAAAA0003, 32'hAAAA0002, 32'hAAAA0001, 32'hAAAA0000}, 32'h00000003, 4'b0010);
    for (int i = 0; i < 7; i++) begin
      @(posedge pclk_i); #1;
      chk("b2b_psel", psel_o, 1);
    end
    @(posedge pclk_i); #1;
    chk("idle_psel", psel_o, 0);
    chk("idle_busy", busy_o, 0);
    chk("idle_pwdata", pwdata_o, 0);
    tick_wait();
    frame(4'b0101, {32'hBBBB0003, 32'hBBBB0002, 32'hBBBB0001, 32'hBBBB0000}, 0, 4'b0000);
    tick_wait();
    chk("err_one", err_cnt_o, 1);
    frame(4'b0000, {32'hCCCC0003, 32'hCCCC0002, 32'hCCCC0001, 32'hCCCC0000}, 0, 4'b0000);
    tick_wait();
    chk("no_en_psel", psel_o, 0);
    chk("no_en_busy", busy_o, 0);
    frame(4'b0001, {32'h0, 32'h0, 32'h0, 32'h77770000}, 32'd20, 4'b0000);
    tick_wait();
    ch_en_i = 4'b1111;
    data_i = {4{32'hDEADBEEF}};
    wait_cyc(70);
    chk("overrun_early", overrun_o, 0);
    wait_cyc(71);
    chk("overrun_pulse", overrun_o, 1);
    chk("overrun_busy", busy_o, 1);
    tick_wait();
    chk("overrun_after", overrun_o, 0);
    frame(4'b0010, {32'h0, 32'h0, 32'h88881111, 32'h0}, 0, 4'b0000);
    tick_wait();
    for (int i = 0; i < 75; i++) begin
      frame(4'b1111, {32'hD3000000 | 32'(i), 32'hD2000000 | 32'(i),
                      32'hD1000000 | 32'(i), 32'hD0000000 | 32'(i)}, 0, 4'b1111);
      tick_wait();
      if (i == 10) chk("err_partial", err_cnt_o, 41);
    end
    frame(4'b0000, '0, 0, 4'b0000);
    tick_wait();
    chk("err_sat", err_cnt_o, 255);
    chk("overrun_count", ovr_n, 1);
    frame(4'b0011, {32'h0, 32'h0, 32'hEEEE0001, 32'hEEEE0000}, 32'h0000000A, 4'b0000);
    tick_wait();
    @(posedge pclk_i);
    @(posedge pclk_i);
    #3 presetn_i = 0;
    #1;
    chk("arst_psel", psel_o, 0);
    chk("arst_penable", penable_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_err", err_cnt_o, 0);
    chk("arst_paddr", paddr_o, 8);
    chk("arst_pwdata", pwdata_o, 0);
    sb.delete();
    rsp_q.delete();
    exp_addr = 8'd8;
    frame(4'b0001, {32'h0, 32'h0, 32'h0, 32'h99990000}, 0, 4'b0000);
    repeat (2) @(negedge pclk_i);
    presetn_i = 1;
    wait_cyc(P - 1);
    chk("rel_pre_tick_psel", psel_o, 0);
    tick_wait();
    chk("rel_tick_psel", psel_o, 1);
    chk("rel_paddr", paddr_o, 8);
    ch_en_i = '0;
    repeat (6) @(posedge pclk_i);
    #1;
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
